uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Byte-level frame receiver and successor to the bit-level frame receiver.
- Consumes bytes from the existing byte deserializer.
- Hunts for a parametrised sync byte, then captures OPT, LEN, a variable payload of up to MAX_MSG_LEN bytes, and an optional CRC-32 trailer.
- Presents the frame on a valid/ready output, reports errors with codes, and recovers from inter-byte timeouts.

Parameters:
- BYTE_SIZE, 8: bits per byte. Must be 8 when CRC_EN=1.
- MAX_MSG_LEN, 16: maximum payload bytes. Range 1..255.
- SYNC_BYTE, 8'h7E: frame start marker.
- CRC_EN, 1: 1 = frame carries CRC_BYTES of CRC-32 after the payload; 0 = no trailer.
- CRC_BYTES, 4: CRC trailer length. Fixed at 4 when CRC_EN=1.
- TIMEOUT_CYC, 100000: maximum idle cycles between bytes inside a frame. 0 disables the timeout.

Ports:
- CLK  in  1  clock
- RST  in  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  byte strobe from the deserializer, one cycle per byte
- in_byte  in  BYTE_SIZE  received byte, qualified by in_valid
- i_ready  in  1  consumer accepts the frame
- o_valid  out  1  frame available; held until i_ready
- o_opt  out  BYTE_SIZE  OPT byte
- o_len  out  BYTE_SIZE  payload length
- o_data  out  MAX_MSG_LEN*BYTE_SIZE  payload; byte k at [k*BYTE_SIZE +: BYTE_SIZE]
- o_err  out  1  single-cycle error pulse
- o_err_code  out  2  0 = overrun, 1 = bad length, 2 = CRC mismatch, 3 = timeout. Valid with o_err; holds last value otherwise.
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE. o_valid, o_err, o_err_code, o_busy, o_opt, o_len, o_data and all counters/CRC are 0.
- States: IDLE, OPT, LEN, DATA, CRC, CHECK, HOLD.
- IDLE: in_valid && in_byte==SYNC_BYTE -> OPT. On that cycle: o_data cleared, CRC reset to 0xFFFFFFFF, byte index cleared. Non-sync bytes are discarded silently.
- OPT: byte -> o_opt; go to LEN. A sync value here is treated as ordinary data.
- LEN: byte -> o_len.
  - If 0 or >MAX_MSG_LEN: o_err code 1 next cycle; go to IDLE.
  - Otherwise go to DATA.
- DATA: byte written to o_data slot idx; idx++. After byte idx==o_len-1: go to CRC if CRC_EN, else HOLD.
- CRC coverage: OPT, LEN and every DATA byte.
- CRC algorithm: CRC-32 IEEE. Poly 0x04C11DB7, init 0xFFFFFFFF, reflected in/out, xorout 0xFFFFFFFF.
- CRC state: receives CRC_BYTES bytes, MSB byte first, into a shift register. After the last byte go to CHECK.
- CHECK: one cycle; compares received vs computed.
  - Match: go to HOLD.
  - Mismatch: o_err code 2; go to IDLE.
- HOLD: o_valid=1 and o_opt/o_len/o_data are stable.
  - i_ready=1: o_valid drops next cycle; go to IDLE. An in_valid byte in the same cycle is evaluated under IDLE rules, so it may be a sync.
  - in_valid while i_ready=0: byte dropped; o_err code 0; remain in HOLD.
- Latency from the in_valid of the last frame byte:
  - CRC_EN=1: o_valid asserts 2 cycles later.
  - CRC_EN=0: o_valid asserts 1 cycle later.
- Timeout counter:
  - Cleared on each accepted byte and in IDLE/CHECK/HOLD.
  - Counts in OPT..CRC.
  - Reaching TIMEOUT_CYC: o_err code 3; go to IDLE. in_valid in the same cycle as expiry: the byte wins and the counter clears.
- Unused o_data slots beyond o_len stay 0.
- Counter widths: idx is $clog2(MAX_MSG_LEN+1) bits; timeout counter is $clog2(TIMEOUT_CYC+1) bits. No wrap is possible within legal ranges.

Decomposition:
- Package uart_pkg holds:
  - state encodings (3 bits)
  - error codes
  - CRC32_POLY, CRC32_INIT, CRC32_XOROUT
  - SYNC_DEFAULT
- Sub-module uart_crc32_byte: combinational next-CRC from (crc_in, byte). The register lives in uart_frame_rx.

Test Plan:
- uart_crc32_byte fed "123456789" from init 0xFFFFFFFF -> final value after xorout is 0xCBF43926.
- Frame 7E,A5,03,11,22,33 + golden CRC, i_ready=1 -> o_valid 2 cycles after the last CRC byte; o_opt=A5, o_len=03, o_data[23:0]=0x332211, upper bytes 0; o_valid held 1 cycle.
- Same frame with the last CRC byte flipped -> o_err pulse, code 2; o_valid never asserts; state back to IDLE (o_busy=0).
- Frame 7E,01,00 and frame 7E,01,(MAX_MSG_LEN+1) -> o_err code 1 each; a following valid frame is received correctly.
- TIMEOUT_CYC=50: 7E,01,02,AA then silence -> o_err code 3 exactly 50 cycles after AA; o_busy=0 afterwards. Repeat with RST asserted mid-DATA -> all outputs 0 immediately, no error pulse.
- Good frame with i_ready=0 for 20 cycles while a byte 0x55 arrives -> o_err code 0; o_data unchanged; o_valid stays 1; i_ready=1 concurrent with byte 7E -> frame accepted and the next frame's OPT is entered.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants for the byte-level UART frame receiver:
//            FSM state encodings, error codes, CRC-32 constants and the
//            default sync byte, plus a bit-reflection helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // FSM state encodings (3 bits)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_OPT   = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CRC   = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_HOLD  = 3'd6;

  // Error codes reported on o_err_code
  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_CRC     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // CRC-32 (IEEE 802.3) constants, normal (non-reflected) polynomial form
  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

  localparam logic [7:0] SYNC_DEFAULT = 8'h7E;

  // Bit-reverse a 32-bit word; turns the normal polynomial into the
  // LSB-first form used by the reflected CRC datapath.
  function automatic logic [31:0] reflect32(input logic [31:0] i_v);
    logic [31:0] w_r;
    w_r = '0;
    for (int i = 0; i < 32; i++) begin
      w_r[i] = i_v[31-i];
    end
    return w_r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_crc32_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_crc32_byte
// Purpose  : Combinational one-byte CRC-32 update (reflected in/out).
//            Produces the next raw CRC register value; init and xorout are
//            applied by the caller.
// Ports    : i_crc  [31:0] current CRC register
//            i_byte [7:0]  byte to absorb (LSB first)
//            o_crc  [31:0] updated CRC register
// Revision : 1.0 - initial release
// ============================================================================
module uart_crc32_byte
  import uart_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  localparam logic [31:0] c_poly_refl = reflect32(CRC32_POLY);

  logic [31:0] w_acc;

  // Reflected CRC: fold the byte into the low bits, then shift right eight
  // times, applying the reflected polynomial whenever a one falls out.
  always_comb begin
    w_acc = i_crc ^ {24'd0, i_byte};
    for (int i = 0; i < 8; i++) begin
      if (w_acc[0]) begin
        w_acc = (w_acc >> 1) ^ c_poly_refl;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
    o_crc = w_acc;
  end

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_rx
// Purpose  : Byte-level frame receiver. Hunts for SYNC_BYTE, captures OPT,
//            LEN, up to MAX_MSG_LEN payload bytes and an optional CRC-32
//            trailer (MSB byte first), then presents the frame on a
//            valid/ready interface. Errors are reported as one-cycle pulses
//            with a code; inter-byte silence inside a frame times out.
// Ports    : CLK, RST           clock, async active-high reset
//            in_valid, in_byte  byte strobe and byte from the deserializer
//            i_ready            consumer accepts the held frame
//            o_valid            frame available (held until i_ready)
//            o_opt, o_len       OPT and LEN bytes
//            o_data             payload, byte k at [k*BYTE_SIZE +: BYTE_SIZE]
//            o_err, o_err_code  error pulse and code (code holds last value)
//            o_busy             high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int                   BYTE_SIZE   = 8,
  parameter int                   MAX_MSG_LEN = 16,
  parameter logic [BYTE_SIZE-1:0] SYNC_BYTE   = BYTE_SIZE'(SYNC_DEFAULT),
  parameter bit                   CRC_EN      = 1'b1,
  parameter int                   CRC_BYTES   = 4,
  parameter int                   TIMEOUT_CYC = 100000
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             in_valid,
  input  logic [BYTE_SIZE-1:0]             in_byte,
  input  logic                             i_ready,
  output logic                             o_valid,
  output logic [BYTE_SIZE-1:0]             o_opt,
  output logic [BYTE_SIZE-1:0]             o_len,
  output logic [MAX_MSG_LEN*BYTE_SIZE-1:0] o_data,
  output logic                             o_err,
  output logic [1:0]                       o_err_code,
  output logic                             o_busy
);

  localparam int c_idx_w  = $clog2(MAX_MSG_LEN + 1);
  localparam int c_cidx_w = (CRC_BYTES > 1) ? $clog2(CRC_BYTES) : 1;
  localparam int c_to_w   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int c_data_w = MAX_MSG_LEN * BYTE_SIZE;

  localparam logic [31:0] c_max_len  = 32'(MAX_MSG_LEN);
  localparam logic [31:0] c_crc_last = 32'(CRC_BYTES - 1);
  localparam logic [31:0] c_to_last  = 32'(TIMEOUT_CYC - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_state_next;
  logic [BYTE_SIZE-1:0]  r_opt;
  logic [BYTE_SIZE-1:0]  r_len;
  logic [c_data_w-1:0]   r_data;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_cidx_w-1:0]   r_cidx;
  logic [c_to_w-1:0]     r_to_cnt;
  logic [31:0]           r_crc;
  logic [31:0]           r_rx_crc;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic [31:0]           w_crc_next;
  logic [7:0]            w_crc_byte;
  logic                  w_sync_hit;
  logic                  w_frame_start;
  logic                  w_in_frame;
  logic                  w_len_bad;
  logic                  w_data_last;
  logic                  w_crc_last;
  logic                  w_crc_match;
  logic                  w_timeout;
  logic                  w_err_set;
  logic [1:0]            w_err_code;

  // CRC engine is always byte-wide; narrower bytes are zero-extended.
  if (BYTE_SIZE >= 8) begin : g_crc_byte_full
    assign w_crc_byte = in_byte[7:0];
  end else begin : g_crc_byte_pad
    assign w_crc_byte = {{(8-BYTE_SIZE){1'b0}}, in_byte};
  end

  uart_crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (w_crc_byte),
    .o_crc  (w_crc_next)
  );

  assign w_sync_hit    = in_valid && (in_byte == SYNC_BYTE);
  // A frame may start from IDLE or directly out of HOLD in the same cycle
  // the consumer accepts the previous frame.
  assign w_frame_start = w_sync_hit &&
                         ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_ready));
  assign w_in_frame    = (r_state == ST_OPT) || (r_state == ST_LEN) ||
                         (r_state == ST_DATA) || (r_state == ST_CRC);
  assign w_len_bad     = (in_byte == '0) || (32'(in_byte) > c_max_len);
  assign w_data_last   = (32'(r_idx) + 32'd1) == 32'(r_len);
  assign w_crc_last    = 32'(r_cidx) == c_crc_last;
  assign w_crc_match   = r_rx_crc == (r_crc ^ CRC32_XOROUT);
  // Expiry fires on the idle cycle that would bring the count to
  // TIMEOUT_CYC; an arriving byte in that cycle takes priority.
  assign w_timeout     = (TIMEOUT_CYC != 0) && w_in_frame && !in_valid &&
                         (32'(r_to_cnt) == c_to_last);

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and error-request logic
  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    w_err_code   = ERR_OVERRUN;
    case (r_state)
      ST_IDLE: begin
        if (w_sync_hit) w_state_next = ST_OPT;
      end
      ST_OPT: begin
        if (in_valid) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        if (in_valid) begin
          if (w_len_bad) begin
            w_state_next = ST_IDLE;
            w_err_set    = 1'b1;
            w_err_code   = ERR_BAD_LEN;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (in_valid && w_data_last) w_state_next = CRC_EN ? ST_CRC : ST_HOLD;
      end
      ST_CRC: begin
        if (in_valid && w_crc_last) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_crc_match) begin
          w_state_next = ST_HOLD;
        end else begin
          w_state_next = ST_IDLE;
          w_err_set    = 1'b1;
          w_err_code   = ERR_CRC;
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          w_state_next = w_sync_hit ? ST_OPT : ST_IDLE;
        end else if (in_valid) begin
          w_err_set  = 1'b1;
          w_err_code = ERR_OVERRUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = ST_IDLE;
      w_err_set    = 1'b1;
      w_err_code   = ERR_TIMEOUT;
    end
  end

  // Output decode
  always_comb begin
    o_valid = (r_state == ST_HOLD);
    o_busy  = (r_state != ST_IDLE);
  end

  // Datapath: captured fields, CRC, counters and error registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_opt      <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_idx      <= '0;
      r_cidx     <= '0;
      r_to_cnt   <= '0;
      r_crc      <= '0;
      r_rx_crc   <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_OVERRUN;
    end else begin
      r_err <= w_err_set;
      if (w_err_set) r_err_code <= w_err_code;

      if (w_frame_start) begin
        r_data <= '0;
        r_crc  <= CRC32_INIT;
        r_idx  <= '0;
        r_cidx <= '0;
      end

      if (in_valid) begin
        case (r_state)
          ST_OPT: begin
            r_opt <= in_byte;
            r_crc <= w_crc_next;
          end
          ST_LEN: begin
            r_len <= in_byte;
            r_crc <= w_crc_next;
          end
          ST_DATA: begin
            r_data[r_idx*BYTE_SIZE +: BYTE_SIZE] <= in_byte;
            r_idx <= r_idx + c_idx_w'(1);
            r_crc <= w_crc_next;
          end
          ST_CRC: begin
            r_rx_crc <= {r_rx_crc[31-BYTE_SIZE:0], in_byte};
            r_cidx   <= r_cidx + c_cidx_w'(1);
          end
          default: ;
        endcase
      end

      if (in_valid || !w_in_frame) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + c_to_w'(1);
      end
    end
  end

  assign o_opt      = r_opt;
  assign o_len      = r_len;
  assign o_data     = r_data;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_rx
// Purpose  : Directed self-checking bench for uart_frame_rx (TIMEOUT_CYC=50)
//            and the uart_crc32_byte update block.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_rx;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         i_ready = 1'b1;
  logic         o_valid;
  logic [7:0]   o_opt;
  logic [7:0]   o_len;
  logic [127:0] o_data;
  logic         o_err;
  logic [1:0]   o_err_code;
  logic         o_busy;

  logic [31:0]  t_crc_in = 32'h0;
  logic [7:0]   t_byte = 8'h0;
  logic [31:0]  t_crc_out;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_frame_rx #(
    .BYTE_SIZE   (8),
    .MAX_MSG_LEN (16),
    .SYNC_BYTE   (8'h7E),
    .CRC_EN      (1'b1),
    .CRC_BYTES   (4),
    .TIMEOUT_CYC (50)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_opt      (o_opt),
    .o_len      (o_len),
    .o_data     (o_data),
    .o_err      (o_err),
    .o_err_code (o_err_code),
    .o_busy     (o_busy)
  );

  uart_crc32_byte u_crc_ref (
    .i_crc  (t_crc_in),
    .i_byte (t_byte),
    .o_crc  (t_crc_out)
  );

  // Bitwise reflected CRC-32 reference, one input bit at a time.
  function automatic logic [31:0] m_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one byte across the next posedge.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] opt, input logic [7:0] n,
                           input logic [127:0] pl, input logic flip);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    c = m_upd(c, opt); send_byte(opt);
    c = m_upd(c, n);   send_byte(n);
    for (int k = 0; k < int'(n); k++) begin
      c = m_upd(c, pl[k*8 +: 8]);
      send_byte(pl[k*8 +: 8]);
    end
    c = c ^ 32'hFFFFFFFF;
    send_byte(c[31:24]);
    send_byte(c[23:16]);
    send_byte(c[15:8]);
    send_byte(c[7:0] ^ {8{flip}});
  endtask

  task automatic send_frame(input logic [7:0] opt, input logic [7:0] n,
                            input logic [127:0] pl, input logic flip);
    send_byte(8'h7E);
    send_body(opt, n, pl, flip);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c;
    logic        saw_err;

    // CRC block and reference against the "123456789" check value
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      t_crc_in = c;
      t_byte   = 8'h31 + 8'(i);
      #1;
      c = t_crc_out;
    end
    check("crc_blk_check", {96'd0, c ^ 32'hFFFFFFFF}, {96'd0, 32'hCBF43926});
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = m_upd(c, 8'h31 + 8'(i));
    check("crc_model_check", {96'd0, c ^ 32'hFFFFFFFF}, {96'd0, 32'hCBF43926});

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_valid", {127'd0, o_valid}, 128'd0);
    check("rst_busy",  {127'd0, o_busy},  128'd0);
    check("rst_err",   {127'd0, o_err},   128'd0);
    check("rst_code",  {126'd0, o_err_code}, 128'd0);
    check("rst_data",  o_data, 128'd0);
    check("rst_optlen", {112'd0, o_opt, o_len}, 128'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Good frame, i_ready high: valid two cycles after the last CRC byte
    send_frame(8'hA5, 8'h03, 128'h332211, 1'b0);
    check("good_lat0_valid", {127'd0, o_valid}, 128'd0);
    check("good_lat0_busy",  {127'd0, o_busy},  128'd1);
    @(negedge CLK);
    check("good_valid", {127'd0, o_valid}, 128'd1);
    check("good_opt",   {120'd0, o_opt}, {120'd0, 8'hA5});
    check("good_len",   {120'd0, o_len}, {120'd0, 8'h03});
    check("good_data",  o_data, 128'h332211);
    check("good_err",   {127'd0, o_err}, 128'd0);
    @(negedge CLK);
    check("good_valid_drop", {127'd0, o_valid}, 128'd0);
    check("good_idle", {127'd0, o_busy}, 128'd0);

    // Same frame with the last CRC byte inverted
    send_frame(8'hA5, 8'h03, 128'h332211, 1'b1);
    check("crcbad_nopulse_yet", {127'd0, o_err}, 128'd0);
    @(negedge CLK);
    check("crcbad_err",   {127'd0, o_err}, 128'd1);
    check("crcbad_code",  {126'd0, o_err_code}, 128'd2);
    check("crcbad_valid", {127'd0, o_valid}, 128'd0);
    check("crcbad_busy",  {127'd0, o_busy}, 128'd0);
    @(negedge CLK);
    check("crcbad_pulse_end", {127'd0, o_err}, 128'd0);
    check("crcbad_valid2", {127'd0, o_valid}, 128'd0);

    // Length 0 and length MAX_MSG_LEN+1
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h00);
    check("len0_err",  {127'd0, o_err}, 128'd1);
    check("len0_code", {126'd0, o_err_code}, 128'd1);
    check("len0_busy", {127'd0, o_busy}, 128'd0);
    @(negedge CLK);
    check("len0_pulse_end", {127'd0, o_err}, 128'd0);
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h11);
    check("len17_err",  {127'd0, o_err}, 128'd1);
    check("len17_code", {126'd0, o_err_code}, 128'd1);
    check("len17_busy", {127'd0, o_busy}, 128'd0);
    @(negedge CLK);

    // Following valid frame; upper payload slots must be cleared
    send_frame(8'h3C, 8'h02, 128'hBEEF, 1'b0);
    @(negedge CLK);
    check("after_len_valid", {127'd0, o_valid}, 128'd1);
    check("after_len_opt",   {120'd0, o_opt}, {120'd0, 8'h3C});
    check("after_len_data",  o_data, 128'hBEEF);
    @(negedge CLK);

    // Maximum length payload
    send_frame(8'h0F, 8'h10, 128'h100F0E0D0C0B0A090807060504030201, 1'b0);
    @(negedge CLK);
    check("max_valid", {127'd0, o_valid}, 128'd1);
    check("max_len",   {120'd0, o_len}, {120'd0, 8'h10});
    check("max_data",  o_data, 128'h100F0E0D0C0B0A090807060504030201);
    @(negedge CLK);

    // Timeout: error 50 clock edges after the edge that took AA
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA);
    repeat (49) @(negedge CLK);
    check("to_early_err",  {127'd0, o_err}, 128'd0);
    check("to_early_busy", {127'd0, o_busy}, 128'd1);
    @(negedge CLK);
    check("to_err",  {127'd0, o_err}, 128'd1);
    check("to_code", {126'd0, o_err_code}, 128'd3);
    check("to_busy", {127'd0, o_busy}, 128'd0);
    @(negedge CLK);

    // Asynchronous reset mid-DATA
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h02); send_byte(8'hAA);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_busy", {127'd0, o_busy}, 128'd0);
    check("arst_code", {126'd0, o_err_code}, 128'd0);
    check("arst_data", o_data, 128'd0);
    check("arst_optlen", {112'd0, o_opt, o_len}, 128'd0);
    check("arst_err_valid", {126'd0, o_err, o_valid}, 128'd0);
    @(negedge CLK);
    RST = 1'b0;
    saw_err = 1'b0;
    repeat (60) begin
      @(negedge CLK);
      if (o_err) saw_err = 1'b1;
    end
    check("arst_no_err", {127'd0, saw_err}, 128'd0);

    // HOLD overrun, then accept concurrently with the next sync
    i_ready = 1'b0;
    send_frame(8'h5A, 8'h01, 128'h99, 1'b0);
    @(negedge CLK);
    check("hold_valid", {127'd0, o_valid}, 128'd1);
    repeat (4) @(negedge CLK);
    send_byte(8'h55);
    check("ovr_err",   {127'd0, o_err}, 128'd1);
    check("ovr_code",  {126'd0, o_err_code}, 128'd0);
    check("ovr_valid", {127'd0, o_valid}, 128'd1);
    check("ovr_data",  o_data, 128'h99);
    repeat (14) @(negedge CLK);
    check("hold_valid_late", {127'd0, o_valid}, 128'd1);
    check("hold_opt_late",   {120'd0, o_opt}, {120'd0, 8'h5A});
    in_valid = 1'b1;
    in_byte  = 8'h7E;
    i_ready  = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
    i_ready  = 1'b0;
    check("accept_valid", {127'd0, o_valid}, 128'd0);
    check("accept_busy",  {127'd0, o_busy}, 128'd1);
    check("accept_clr",   o_data, 128'd0);
    send_body(8'hC3, 8'h02, 128'h0201, 1'b0);
    i_ready = 1'b1;
    @(negedge CLK);
    check("next_valid", {127'd0, o_valid}, 128'd1);
    check("next_opt",   {120'd0, o_opt}, {120'd0, 8'hC3});
    check("next_data",  o_data, 128'h0201);
    @(negedge CLK);
    check("next_drop",  {127'd0, o_valid}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
